// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: captures ALU results and EX control, resolves beq/bne
// from the registered zero flag, squashes the wrong-path instruction and counts taken branches.
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic               ex_zero,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] ex_dest_reg,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_branch,
    input  logic               ex_branch_ne,
    input  logic [DATA_W-1:0]  ex_br_target,
    input  logic               stall,
    input  logic               flush,
    output logic               ex_ready,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_alu_result,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [RADDR_W-1:0] mem_dest_reg,
    output logic               mem_reg_write,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               pc_src,
    output logic [DATA_W-1:0]  pc_target,
    output logic               fwd_valid,
    output logic [CNT_W-1:0]   br_taken_cnt
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic               zero_q, zero_d;
    logic [DATA_W-1:0]  store_q, store_d;
    logic [RADDR_W-1:0] dest_q, dest_d;
    logic               rw_q, rw_d;
    logic               mr_q, mr_d;
    logic               mw_q, mw_d;
    logic               br_q, br_d;
    logic               br_ne_q, br_ne_d;
    logic [DATA_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               taken;

    // Branch resolution uses only registered values, so pc_src is glitch-free from the flops.
    assign taken = valid_q & ((br_q & zero_q) | (br_ne_q & ~zero_q));

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        zero_d  = zero_q;
        store_d = store_q;
        dest_d  = dest_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        br_d    = br_q;
        br_ne_d = br_ne_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        if (!stall) begin
            // The instruction sitting in EX while a branch is taken is wrong-path.
            valid_d = ex_valid & ~taken & ~flush;
            alu_d   = ex_alu_result;
            zero_d  = ex_zero;
            store_d = ex_store_data;
            dest_d  = ex_dest_reg;
            rw_d    = ex_reg_write;
            mr_d    = ex_mem_read;
            mw_d    = ex_mem_write;
            br_d    = ex_branch;
            br_ne_d = ex_branch_ne;
            tgt_d   = ex_br_target;
        end else if (flush) begin
            valid_d = 1'b0;
        end

        // Count on the edge where the taken entry leaves, so a long stall counts it once.
        if (taken && (!stall || flush) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            zero_q  <= 1'b0;
            store_q <= '0;
            dest_q  <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            br_q    <= 1'b0;
            br_ne_q <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            zero_q  <= zero_d;
            store_q <= store_d;
            dest_q  <= dest_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            br_q    <= br_d;
            br_ne_q <= br_ne_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_ready       = ~stall;
    assign mem_valid      = valid_q;
    assign mem_alu_result = alu_q;
    assign mem_store_data = store_q;
    assign mem_dest_reg   = dest_q;
    assign mem_reg_write  = valid_q & rw_q;
    assign mem_mem_read   = valid_q & mr_q;
    assign mem_mem_write  = valid_q & mw_q;
    assign pc_src         = taken;
    assign pc_target      = tgt_q;
    assign fwd_valid      = valid_q & rw_q & (dest_q != '0);
    assign br_taken_cnt   = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + random bench for ex_mem_stage; a 16-bit and a 2-bit counter instance share stimulus.
module tb_ex_mem_stage;
    localparam int OBS_W = 126;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic        ex_zero = 1'b0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_dest_reg = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic        ex_branch = 1'b0;
    logic        ex_branch_ne = 1'b0;
    logic [31:0] ex_br_target = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, pc_src, fwd_valid;
    logic [31:0] mem_alu_result, mem_store_data, pc_target;
    logic [4:0]  mem_dest_reg;
    logic [15:0] br_taken_cnt;

    logic        s_ex_ready, s_mem_valid, s_mem_reg_write, s_mem_mem_read, s_mem_mem_write, s_pc_src, s_fwd_valid;
    logic [31:0] s_mem_alu_result, s_mem_store_data, s_pc_target;
    logic [4:0]  s_mem_dest_reg;
    logic [1:0]  s_br_taken_cnt;

    int tests = 0;
    int fails = 0;
    logic [OBS_W-1:0] exp_q[$];

    // model state
    logic        m_valid, m_zero, m_rw, m_mr, m_mw, m_br, m_brne;
    logic [31:0] m_alu, m_store, m_tgt;
    logic [4:0]  m_dest;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_zero(ex_zero), .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_br_target(ex_br_target),
        .stall(stall), .flush(flush), .ex_ready(ex_ready), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_dest_reg(mem_dest_reg), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .pc_src(pc_src), .pc_target(pc_target),
        .fwd_valid(fwd_valid), .br_taken_cnt(br_taken_cnt)
    );

    ex_mem_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_zero(ex_zero), .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_br_target(ex_br_target),
        .stall(stall), .flush(flush), .ex_ready(s_ex_ready), .mem_valid(s_mem_valid),
        .mem_alu_result(s_mem_alu_result), .mem_store_data(s_mem_store_data),
        .mem_dest_reg(s_mem_dest_reg), .mem_reg_write(s_mem_reg_write), .mem_mem_read(s_mem_mem_read),
        .mem_mem_write(s_mem_mem_write), .pc_src(s_pc_src), .pc_target(s_pc_target),
        .fwd_valid(s_fwd_valid), .br_taken_cnt(s_br_taken_cnt)
    );

    function automatic logic [OBS_W-1:0] dut_obs();
        return {mem_valid, mem_alu_result, mem_store_data, mem_dest_reg, mem_reg_write,
                mem_mem_read, mem_mem_write, pc_src, pc_target, fwd_valid, ex_ready,
                br_taken_cnt, s_br_taken_cnt};
    endfunction

    function automatic logic model_taken();
        return m_valid & ((m_br & m_zero) | (m_brne & ~m_zero));
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        return {m_valid, m_alu, m_store, m_dest, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw,
                model_taken(), m_tgt, m_valid & m_rw & (m_dest != 5'd0), ~stall, m_cnt, m_cnt2};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_brne = 0;
        m_alu = '0; m_store = '0; m_tgt = '0; m_dest = '0; m_cnt = '0; m_cnt2 = '0;
    endtask

    task automatic model_edge();
        logic t;
        t = model_taken();
        if (t && (!stall || flush)) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
        if (!stall) begin
            m_valid = ex_valid & ~t & ~flush;
            m_alu = ex_alu_result; m_zero = ex_zero; m_store = ex_store_data; m_dest = ex_dest_reg;
            m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
            m_br = ex_branch; m_brne = ex_branch_ne; m_tgt = ex_br_target;
        end else if (flush) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push expectation, advance one edge, then pop and compare the whole output vector.
    task automatic step(input string tag);
        logic [OBS_W-1:0] e;
        model_edge();
        @(posedge clk);
        #1;
        exp_q.push_back(model_obs());
        e = exp_q.pop_front();
        tests++;
        assert (dut_obs() === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, dut_obs(), e);
        end
    endtask

    task automatic set_alu(input logic [31:0] alu, input logic [4:0] dest, input logic rw);
        ex_valid = 1; ex_alu_result = alu; ex_dest_reg = dest; ex_reg_write = rw;
        ex_store_data = alu ^ 32'hA5A5_0000; ex_mem_read = 0; ex_mem_write = 0;
        ex_branch = 0; ex_branch_ne = 0; ex_zero = 0; ex_br_target = alu + 32'd4;
    endtask

    task automatic set_branch(input logic ne, input logic zero, input logic [31:0] tgt);
        ex_valid = 1; ex_alu_result = 32'h0; ex_dest_reg = 5'd0; ex_reg_write = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_branch = ~ne; ex_branch_ne = ne;
        ex_zero = zero; ex_br_target = tgt;
    endtask

    initial begin
        model_reset();
        // reset with a valid instruction presented
        set_alu(32'hDEAD_BEEF, 5'd3, 1'b1);
        #2;
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_pc_src", {31'b0, pc_src}, 32'd0);
        chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("rst_cnt", {16'b0, br_taken_cnt}, 32'd0);
        chk("rst_alu", mem_alu_result, 32'd0);
        chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        stall = 1; #1;
        chk("rst_ex_ready_stall", {31'b0, ex_ready}, 32'd0);
        stall = 0;
        @(posedge clk); #1;
        chk("rst_hold_valid", {31'b0, mem_valid}, 32'd0);
        @(negedge clk); rst_n = 1;

        step("first_capture");
        chk("first_capture_valid", {31'b0, mem_valid}, 32'd1);

        set_alu(32'h0000_1234, 5'd8, 1'b1);
        step("alu_pass");
        chk("alu_result", mem_alu_result, 32'h0000_1234);
        chk("fwd_dest8", {31'b0, fwd_valid}, 32'd1);
        set_alu(32'h0000_5678, 5'd0, 1'b1);
        step("alu_dest0");
        chk("fwd_dest0", {31'b0, fwd_valid}, 32'd0);

        // beq taken, then wrong-path instruction squashed
        set_branch(1'b0, 1'b1, 32'h0040_0020);
        step("beq_taken");
        chk("beq_pc_src", {31'b0, pc_src}, 32'd1);
        chk("beq_target", pc_target, 32'h0040_0020);
        set_alu(32'h0000_0111, 5'd9, 1'b1);
        step("beq_squash");
        chk("squash_valid", {31'b0, mem_valid}, 32'd0);
        chk("squash_pc_src", {31'b0, pc_src}, 32'd0);
        chk("beq_cnt", {16'b0, br_taken_cnt}, 32'd1);

        // bne not taken
        set_branch(1'b1, 1'b1, 32'h0040_0100);
        step("bne_nt");
        chk("bne_pc_src", {31'b0, pc_src}, 32'd0);
        set_alu(32'h0000_0222, 5'd10, 1'b1);
        step("bne_follow");
        chk("bne_follow_valid", {31'b0, mem_valid}, 32'd1);
        chk("bne_cnt", {16'b0, br_taken_cnt}, 32'd1);

        // taken branch held through a 3-cycle stall
        set_branch(1'b1, 1'b0, 32'h0040_0200);
        step("bne_taken");
        set_alu(32'h0000_0333, 5'd11, 1'b1);
        stall = 1;
        for (int i = 0; i < 3; i++) step("stall_hold");
        chk("stall_pc_src", {31'b0, pc_src}, 32'd1);
        chk("stall_cnt", {16'b0, br_taken_cnt}, 32'd1);
        stall = 0;
        step("stall_release");
        chk("release_cnt", {16'b0, br_taken_cnt}, 32'd2);

        // flush beats stall
        set_alu(32'h0000_0444, 5'd12, 1'b1);
        step("pre_flush");
        stall = 1; flush = 1;
        step("flush_stall");
        chk("flush_valid", {31'b0, mem_valid}, 32'd0);
        chk("flush_rw", {31'b0, mem_reg_write}, 32'd0);
        stall = 0; flush = 0;

        // reset in the middle of a stalled taken branch
        set_branch(1'b0, 1'b1, 32'h0040_0300);
        step("pre_rst_branch");
        stall = 1;
        step("pre_rst_stall");
        rst_n = 0; #1;
        model_reset();
        chk("midrst_pc_src", {31'b0, pc_src}, 32'd0);
        chk("midrst_cnt", {16'b0, br_taken_cnt}, 32'd0);
        @(negedge clk); rst_n = 1; stall = 0;

        // five taken branches separated by ordinary instructions
        for (int i = 0; i < 5; i++) begin
            set_branch(1'b0, 1'b1, 32'h0050_0000 + 32'(i) * 32'd16);
            step("sat_branch");
            set_alu(32'(i), 5'd1, 1'b1);
            step("sat_gap");
        end
        chk("sat_cnt2", {30'b0, s_br_taken_cnt}, 32'd3);
        chk("sat_cnt16", {16'b0, br_taken_cnt}, 32'd5);

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            ex_valid      = 1'($urandom_range(0, 3) != 0);
            ex_alu_result = $urandom;
            ex_store_data = $urandom;
            ex_dest_reg   = 5'($urandom_range(0, 31));
            ex_zero       = 1'($urandom_range(0, 1));
            ex_br_target  = $urandom;
            case ($urandom_range(0, 2))
                0: begin ex_branch = 0; ex_branch_ne = 0; end
                1: begin ex_branch = 1; ex_branch_ne = 0; end
                default: begin ex_branch = 0; ex_branch_ne = 1; end
            endcase
            ex_reg_write  = ~(ex_branch | ex_branch_ne) & 1'($urandom_range(0, 1));
            ex_mem_read   = ~(ex_branch | ex_branch_ne) & 1'($urandom_range(0, 1));
            ex_mem_write  = ~(ex_branch | ex_branch_ne) & ~ex_mem_read & 1'($urandom_range(0, 1));
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
